fp_add_scheduler: RTL

//  Shares one registered FP32 adder (sign/exp/mantissa datapath, result registered on clk) among NREQ requesters.

---
 rtl/fp_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/fp_add_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 constants and small helpers for the shared-adder scheduler.
package fp_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned SIGN_BIT = XLEN - 1;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_LSB  = MAN_W;

  // Width of an index able to address n requesters; never below one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above ptr, with wrap.
module rr_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid
);

  logic [IDW-1:0] ptr;
  int unsigned    j;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!grant_valid && req[IDW'(j)]) begin
        grant_valid        = 1'b1;
        grant[IDW'(j)]     = 1'b1;
        grant_id           = IDW'(j);
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one external registered FP32 adder among NREQ requesters with
// round-robin issue, ID-tagged latency tracking and per-requester result slots.
module fp_add_scheduler
  import fp_pkg::clog2;
#(
  parameter int unsigned XLEN = fp_pkg::XLEN,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*XLEN-1:0] rsp_data,
  output logic [XLEN-1:0]      add_a,
  output logic [XLEN-1:0]      add_b,
  input  logic [XLEN-1:0]      add_result,
  output logic                 busy
);

  localparam int unsigned IDW = clog2(NREQ);

  logic [NREQ-1:0]         pending;
  logic [NREQ-1:0]         eligible;
  logic [NREQ-1:0]         grant;
  logic [IDW-1:0]          grant_id;
  logic                    grant_valid;
  logic [XLEN-1:0]         sel_a;
  logic [XLEN-1:0]         sel_b;
  logic [LAT:0]            tag_v;
  logic [LAT:0][IDW-1:0]   tag_id;
  logic                    cap_v;
  logic [IDW-1:0]          cap_id;

  // A requester with a result still outstanding or parked may not issue again.
  assign eligible  = req_valid & ~pending & {NREQ{~rst}};
  assign req_ready = grant;
  assign busy      = |pending;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (eligible),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Subtract is issued as an add with the sign of B inverted.
  always_comb begin
    sel_a = req_a[32'(grant_id) * XLEN +: XLEN];
    sel_b = req_b[32'(grant_id) * XLEN +: XLEN]
          ^ {req_sub[grant_id], {(XLEN - 1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a <= '0;
      add_b <= '0;
    end else if (grant_valid) begin
      add_a <= sel_a;
      add_b <= sel_b;
    end
  end

  // Tag shift pipe: stage LAT lines up with add_result for the op it carries.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= grant_valid;
      tag_id[0] <= grant_id;
      for (int unsigned s = 1; s <= LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign cap_v  = tag_v[LAT];
  assign cap_id = tag_id[LAT];

  // Response slots and pending bits; capture and drain never hit the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      pending   <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (cap_v && cap_id == IDW'(i)) begin
          rsp_valid[i]                <= 1'b1;
          rsp_data[i*XLEN +: XLEN]    <= add_result;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
        if (grant[i]) begin
          pending[i] <= 1'b1;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // A result must never land on a slot that still holds an unconsumed one.
  always @(posedge clk) begin
    if (!rst && cap_v) begin
      assert (!rsp_valid[cap_id]);
    end
  end

endmodule
